sprite_renderer: RTL and testbench



---
 rtl/display_pkg.sv | 13 +
 rtl/pipe_delay.sv | 32 +++
 rtl/sprite_renderer.sv | 128 ++++++++++++
 tb/tb_sprite_renderer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Raster geometry and colour helpers shared by the display path.
// No logic state; constants and one pure function.
package display_pkg;

  localparam int HCOUNT_W = 10;
  localparam int VCOUNT_W = 9;
  localparam int RGB_W    = 12;

  function automatic logic [RGB_W-1:0] rgb888_to_444(input logic [23:0] c);
    return {c[23:20], c[15:12], c[7:4]};
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth W-bit shift register cleared by synchronous reset; DEPTH=0 is a wire.
// Latency DEPTH cycles, no backpressure: one word per cycle.
module pipe_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_dat = i_dat;
    end else begin : g_shift
      logic [W-1:0] r_sr [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= i_dat;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_dat = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sprite_renderer.sv
// Sprite blitter: window test, flipped ROM addressing, palette lookup and colour-key; latency 1+ROM+PAL+1.
// No backpressure: one raster position in and one pixel out every cycle.
module sprite_renderer
  import display_pkg::*;
#(
  parameter int WIDTH           = 437,
  parameter int HEIGHT          = 277,
  parameter int ADDR_W          = 17,
  parameter int INDEX_W         = 8,
  parameter int ROM_LATENCY     = 2,
  parameter int PAL_LATENCY     = 2,
  parameter int TRANSPARENT_IDX = 0,
  parameter int X_INIT          = 101,
  parameter int Y_INIT          = 103
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic [HCOUNT_W-1:0] x_in,
  input  logic [VCOUNT_W-1:0] y_in,
  input  logic                flip_h_in,
  input  logic                flip_v_in,
  output logic [ADDR_W-1:0]   rom_addr_out,
  input  logic [INDEX_W-1:0]  rom_data_in,
  output logic [INDEX_W-1:0]  pal_addr_out,
  input  logic [23:0]         pal_data_in,
  output logic [RGB_W-1:0]    pixel_out,
  output logic                hit_out
);

  logic [HCOUNT_W-1:0] r_xl;
  logic [VCOUNT_W-1:0] r_yl;
  logic                r_fh;
  logic                r_fv;
  logic                r_win0;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [RGB_W-1:0]    r_pixel;
  logic                r_hit;

  logic                w_frame_start;
  logic [HCOUNT_W-1:0] w_xl;
  logic [VCOUNT_W-1:0] w_yl;
  logic                w_fh;
  logic                w_fv;
  logic [HCOUNT_W:0]   w_x_end;
  logic [VCOUNT_W:0]   w_y_end;
  logic                w_in_win;
  logic [HCOUNT_W-1:0] w_rx;
  logic [VCOUNT_W-1:0] w_ry;
  logic [HCOUNT_W-1:0] w_rx_f;
  logic [VCOUNT_W-1:0] w_ry_f;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_transp;
  logic                w_win_d;
  logic                w_transp_d;

  // The (0,0) sample itself must already see the newly requested position/flip.
  assign w_frame_start = (hcount_in == '0) && (vcount_in == '0);
  assign w_xl = w_frame_start ? x_in      : r_xl;
  assign w_yl = w_frame_start ? y_in      : r_yl;
  assign w_fh = w_frame_start ? flip_h_in : r_fh;
  assign w_fv = w_frame_start ? flip_v_in : r_fv;

  // One extra bit keeps the right/bottom edge from wrapping, so sprites clip.
  assign w_x_end  = {1'b0, w_xl} + (HCOUNT_W+1)'(WIDTH);
  assign w_y_end  = {1'b0, w_yl} + (VCOUNT_W+1)'(HEIGHT);
  assign w_in_win = (hcount_in >= w_xl) && ({1'b0, hcount_in} < w_x_end) &&
                    (vcount_in >= w_yl) && ({1'b0, vcount_in} < w_y_end);

  assign w_rx   = hcount_in - w_xl;
  assign w_ry   = vcount_in - w_yl;
  assign w_rx_f = w_fh ? HCOUNT_W'(WIDTH - 1) - w_rx : w_rx;
  assign w_ry_f = w_fv ? VCOUNT_W'(HEIGHT - 1) - w_ry : w_ry;
  assign w_addr = ADDR_W'(w_ry_f) * ADDR_W'(WIDTH) + ADDR_W'(w_rx_f);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_xl       <= HCOUNT_W'(X_INIT);
      r_yl       <= VCOUNT_W'(Y_INIT);
      r_fh       <= 1'b0;
      r_fv       <= 1'b0;
      r_rom_addr <= '0;
      r_win0     <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_xl <= x_in;
        r_yl <= y_in;
        r_fh <= flip_h_in;
        r_fv <= flip_v_in;
      end
      r_rom_addr <= w_in_win ? w_addr : '0;
      r_win0     <= w_in_win;
    end
  end

  assign rom_addr_out = r_rom_addr;
  assign pal_addr_out = rom_data_in;
  assign w_transp     = (rom_data_in == INDEX_W'(TRANSPARENT_IDX));

  pipe_delay #(.W(1), .DEPTH(ROM_LATENCY + PAL_LATENCY)) u_win_dly (
    .i_clk (pixel_clk_in),
    .i_rst (rst_in),
    .i_dat (r_win0),
    .o_dat (w_win_d)
  );

  pipe_delay #(.W(1), .DEPTH(PAL_LATENCY)) u_transp_dly (
    .i_clk (pixel_clk_in),
    .i_rst (rst_in),
    .i_dat (w_transp),
    .o_dat (w_transp_d)
  );

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_pixel <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_pixel <= (w_win_d && !w_transp_d) ? rgb888_to_444(pal_data_in) : '0;
      r_hit   <= w_win_d && !w_transp_d;
    end
  end

  assign pixel_out = r_pixel;
  assign hit_out   = r_hit;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with behavioural 2-cycle image ROM and palette models.
module tb_sprite_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  hcount = 10'd5;
  logic [8:0]  vcount = 9'd5;
  logic [9:0]  x_in = 10'd101;
  logic [8:0]  y_in = 9'd103;
  logic        fh_in = 1'b0;
  logic        fv_in = 1'b0;
  logic [16:0] rom_addr_out;
  logic [7:0]  rom_data_in;
  logic [7:0]  pal_addr_out;
  logic [23:0] pal_data_in;
  logic [11:0] pixel_out;
  logic        hit_out;

  int errors = 0;
  int checks = 0;

  sprite_renderer dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .x_in         (x_in),
    .y_in         (y_in),
    .flip_h_in    (fh_in),
    .flip_v_in    (fv_in),
    .rom_addr_out (rom_addr_out),
    .rom_data_in  (rom_data_in),
    .pal_addr_out (pal_addr_out),
    .pal_data_in  (pal_data_in),
    .pixel_out    (pixel_out),
    .hit_out      (hit_out)
  );

  always #5 clk = ~clk;

  // Image content: index 0 (transparent) only at address 5, otherwise (addr mod 255)+1.
  function automatic logic [7:0] rom_fn(input logic [16:0] a);
    if (a == 17'd5) return 8'd0;
    return 8'((a % 17'd255) + 17'd1);
  endfunction

  // Palette: entry 7 is F08040; others give RGB444 = {i[3:0], ~i[3:0], i[7:4]}.
  function automatic logic [23:0] pal_fn(input logic [7:0] i);
    if (i == 8'd7) return 24'hF08040;
    return {i[3:0], 4'h3, ~i[3:0], 4'h0, i[7:4], 4'h0};
  endfunction

  logic [7:0]  rom_q0 = 8'd0, rom_q1 = 8'd0;
  logic [23:0] pal_q0 = 24'd0, pal_q1 = 24'd0;
  always @(posedge clk) begin
    rom_q0 <= rom_fn(rom_addr_out);
    rom_q1 <= rom_q0;
    pal_q0 <= pal_fn(pal_addr_out);
    pal_q1 <= pal_q0;
  end
  assign rom_data_in = rom_q1;
  assign pal_data_in = pal_q1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start(input logic [9:0] x, input logic [8:0] y,
                             input logic h, input logic v);
    x_in = x; y_in = y; fh_in = h; fv_in = v;
    hcount = 10'd0; vcount = 9'd0;
    tick();
    hcount = 10'd5; vcount = 9'd5;
  endtask

  // Samples one position, then idles off-window until its pixel reaches the output.
  task automatic run_pixel(input logic [9:0] h, input logic [8:0] v,
                           output logic [16:0] addr, output logic [11:0] pix,
                           output logic hit);
    hcount = h; vcount = v;
    tick();
    addr = rom_addr_out;
    hcount = 10'd5; vcount = 9'd5;
    repeat (5) tick();
    pix = pixel_out;
    hit = hit_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (rom_addr_out !== 17'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_addr_out); end
    checks++; if (pixel_out !== 12'h000) begin errors++; $display("FAIL reset_pixel got %h want 000", pixel_out); end
    checks++; if (hit_out !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", hit_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_defaults();
    logic [16:0] a; logic [11:0] p; logic h;
    run_pixel(10'd101, 9'd103, a, p, h);
    checks++; if (a !== 17'd0 || p !== 12'h1E0 || h !== 1'b1) begin errors++; $display("FAIL def_101_103 got addr=%0d pix=%h hit=%b want 0 1E0 1", a, p, h); end
    run_pixel(10'd102, 9'd103, a, p, h);
    checks++; if (a !== 17'd1 || p !== 12'h2D0 || h !== 1'b1) begin errors++; $display("FAIL def_102_103 got addr=%0d pix=%h hit=%b want 1 2D0 1", a, p, h); end
    run_pixel(10'd101, 9'd104, a, p, h);
    checks++; if (a !== 17'd437 || p !== 12'h78B || h !== 1'b1) begin errors++; $display("FAIL def_101_104 got addr=%0d pix=%h hit=%b want 437 78B 1", a, p, h); end
  endtask

  task automatic test_edges();
    logic [16:0] a; logic [11:0] p; logic h;
    run_pixel(10'd100, 9'd103, a, p, h);
    checks++; if (a !== 17'd0 || p !== 12'h000 || h !== 1'b0) begin errors++; $display("FAIL edge_left got addr=%0d pix=%h hit=%b want 0 000 0", a, p, h); end
    run_pixel(10'd538, 9'd103, a, p, h);
    checks++; if (a !== 17'd0 || p !== 12'h000 || h !== 1'b0) begin errors++; $display("FAIL edge_right got addr=%0d pix=%h hit=%b want 0 000 0", a, p, h); end
    run_pixel(10'd537, 9'd103, a, p, h);
    checks++; if (a !== 17'd436 || p !== 12'h69B || h !== 1'b1) begin errors++; $display("FAIL edge_last_col got addr=%0d pix=%h hit=%b want 436 69B 1", a, p, h); end
    run_pixel(10'd101, 9'd379, a, p, h);
    checks++; if (a !== 17'd120612 || p !== 12'hD2F || h !== 1'b1) begin errors++; $display("FAIL edge_last_row got addr=%0d pix=%h hit=%b want 120612 D2F 1", a, p, h); end
    run_pixel(10'd101, 9'd380, a, p, h);
    checks++; if (h !== 1'b0 || p !== 12'h000) begin errors++; $display("FAIL edge_bottom got pix=%h hit=%b want 000 0", p, h); end
    frame_start(10'd900, 9'd103, 1'b0, 1'b0);
    run_pixel(10'd1000, 9'd103, a, p, h);
    checks++; if (a !== 17'd100 || p !== 12'h5A6 || h !== 1'b1) begin errors++; $display("FAIL clip_in got addr=%0d pix=%h hit=%b want 100 5A6 1", a, p, h); end
    run_pixel(10'd100, 9'd103, a, p, h);
    checks++; if (a !== 17'd0 || h !== 1'b0) begin errors++; $display("FAIL clip_nowrap got addr=%0d hit=%b want 0 0", a, h); end
    frame_start(10'd101, 9'd103, 1'b0, 1'b0);
  endtask

  task automatic test_flip();
    logic [16:0] a; logic [11:0] p; logic h;
    frame_start(10'd101, 9'd103, 1'b1, 1'b1);
    run_pixel(10'd101, 9'd103, a, p, h);
    checks++; if (a !== 17'd121048 || p !== 12'h3CB || h !== 1'b1) begin errors++; $display("FAIL flip_hv got addr=%0d pix=%h hit=%b want 121048 3CB 1", a, p, h); end
    run_pixel(10'd102, 9'd103, a, p, h);
    checks++; if (a !== 17'd121047 || p !== 12'h2DB) begin errors++; $display("FAIL flip_next got addr=%0d pix=%h want 121047 2DB", a, p); end
    fh_in = 1'b0; fv_in = 1'b0;
    run_pixel(10'd101, 9'd103, a, p, h);
    checks++; if (a !== 17'd121048) begin errors++; $display("FAIL flip_midframe got addr=%0d want 121048", a); end
    frame_start(10'd101, 9'd103, 1'b0, 1'b0);
    run_pixel(10'd101, 9'd103, a, p, h);
    checks++; if (a !== 17'd0) begin errors++; $display("FAIL flip_cleared got addr=%0d want 0", a); end
  endtask

  task automatic test_transparency();
    logic [16:0] a; logic [11:0] p; logic h;
    run_pixel(10'd106, 9'd103, a, p, h);
    checks++; if (a !== 17'd5 || p !== 12'h000 || h !== 1'b0) begin errors++; $display("FAIL transp got addr=%0d pix=%h hit=%b want 5 000 0", a, p, h); end
    hcount = 10'd107; vcount = 9'd103;
    tick();
    hcount = 10'd5; vcount = 9'd5;
    repeat (2) tick();
    checks++; if (pal_addr_out !== 8'd7) begin errors++; $display("FAIL pal_addr got %0d want 7", pal_addr_out); end
    repeat (3) tick();
    checks++; if (pixel_out !== 12'hF84 || hit_out !== 1'b1) begin errors++; $display("FAIL opaque_idx7 got pix=%h hit=%b want F84 1", pixel_out, hit_out); end
  endtask

  task automatic test_latch();
    logic [16:0] a; logic [11:0] p; logic h;
    hcount = 10'd50; vcount = 9'd200;
    x_in = 10'd200;
    tick();
    run_pixel(10'd101, 9'd103, a, p, h);
    checks++; if (a !== 17'd0 || h !== 1'b1) begin errors++; $display("FAIL latch_hold got addr=%0d hit=%b want 0 1", a, h); end
    run_pixel(10'd200, 9'd103, a, p, h);
    checks++; if (a !== 17'd99) begin errors++; $display("FAIL latch_hold99 got addr=%0d want 99", a); end
    frame_start(10'd200, 9'd103, 1'b0, 1'b0);
    run_pixel(10'd201, 9'd103, a, p, h);
    checks++; if (a !== 17'd1 || h !== 1'b1) begin errors++; $display("FAIL latch_moved got addr=%0d hit=%b want 1 1", a, h); end
    run_pixel(10'd101, 9'd103, a, p, h);
    checks++; if (h !== 1'b0 || p !== 12'h000) begin errors++; $display("FAIL latch_old_gone got pix=%h hit=%b want 000 0", p, h); end
    // Frame-start sample at (0,0) with a sprite at (0,0) must already be drawn.
    x_in = 10'd0; y_in = 9'd0;
    run_pixel(10'd0, 9'd0, a, p, h);
    checks++; if (a !== 17'd0 || p !== 12'h1E0 || h !== 1'b1) begin errors++; $display("FAIL latch_same_sample got addr=%0d pix=%h hit=%b want 0 1E0 1", a, p, h); end
    frame_start(10'd200, 9'd103, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [16:0] a; logic [11:0] p; logic h;
    hcount = 10'd250; vcount = 9'd150;
    tick();
    checks++; if (rom_addr_out !== 17'd20589) begin errors++; $display("FAIL pre_reset_addr got %0d want 20589", rom_addr_out); end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++; if (pixel_out !== 12'h000 || hit_out !== 1'b0 || rom_addr_out !== 17'd0) begin errors++; $display("FAIL rst_edge got pix=%h hit=%b addr=%0d want 000 0 0", pixel_out, hit_out, rom_addr_out); end
    rst = 1'b0;
    tick();
    checks++; if (rom_addr_out !== 17'd20688) begin errors++; $display("FAIL rst_latch_addr got %0d want 20688", rom_addr_out); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (pixel_out !== 12'h000 || hit_out !== 1'b0) begin errors++; $display("FAIL rst_flush cycle %0d got pix=%h hit=%b want 000 0", i, pixel_out, hit_out); end
      if (i < 4) tick();
    end
    tick();
    checks++; if (pixel_out !== 12'h2D2 || hit_out !== 1'b1) begin errors++; $display("FAIL rst_first_pixel got pix=%h hit=%b want 2D2 1", pixel_out, hit_out); end
    // Reset coinciding with frame start: INIT values win over the request.
    x_in = 10'd300; y_in = 9'd10;
    hcount = 10'd0; vcount = 9'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_pixel(10'd102, 9'd103, a, p, h);
    checks++; if (a !== 17'd1 || h !== 1'b1) begin errors++; $display("FAIL rst_vs_frame got addr=%0d hit=%b want 1 1", a, h); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_edges();
    test_flip();
    test_transparency();
    test_latch();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
